// File: rtl/alu_pipe.sv
// Handshaked ALU stage between register-file read and writeback: single-cycle ops plus an
// iterative shift-add multiply, registered result and Z/N/V flags, valid/ready on both sides.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [2:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             busy
);

  // state | meaning
  // IDLE  | accepting operands, single-cycle ops complete here
  // MUL   | shift-add multiply running, one multiplier bit per cycle
  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOTB = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  state_t                 state_q, state_d;
  logic [2*WIDTH-1:0]     acc_q, mcand_q, acc_next;
  logic [WIDTH-1:0]       b_q;
  logic [SHW-1:0]         cnt_q;
  logic [WIDTH-1:0]       sum, diff, alu_res, res_d;
  logic                   alu_v, v_d;
  logic                   accept, start_mul, load_alu, load_mul;

  assign in_ready = (state_q == IDLE) & (~out_valid | out_ready) & ~reset;
  assign accept   = in_valid & in_ready;
  assign busy     = (state_q == MUL);

  assign sum      = Ain + Bin;
  assign diff     = Ain - Bin;
  // Multiplicand is pre-shifted and the multiplier shifted right, so bit 0 is always the live bit.
  assign acc_next = acc_q + (b_q[0] ? mcand_q : '0);

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (ALUop)
      OP_ADD: begin
        alu_res = sum;
        alu_v   = (Ain[WIDTH-1] == Bin[WIDTH-1]) & (sum[WIDTH-1] != Ain[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_v   = (Ain[WIDTH-1] != Bin[WIDTH-1]) & (diff[WIDTH-1] != Ain[WIDTH-1]);
      end
      OP_AND:  alu_res = Ain & Bin;
      OP_NOTB: alu_res = ~Bin;
      OP_OR:   alu_res = Ain | Bin;
      OP_XOR:  alu_res = Ain ^ Bin;
      OP_SHL:  alu_res = Ain << Bin[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    start_mul = 1'b0;
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (ALUop == OP_MUL) begin
            start_mul = 1'b1;
            state_d   = MUL;
          end else begin
            load_alu = 1'b1;
          end
        end
      end
      MUL: begin
        if (cnt_q == '0) begin
          load_mul = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign res_d = load_mul ? acc_next[WIDTH-1:0] : alu_res;
  assign v_d   = load_mul ? (|acc_next[2*WIDTH-1:WIDTH]) : alu_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      out       <= '0;
      Z         <= 1'b0;
      N         <= 1'b0;
      V         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_mul) begin
        mcand_q <= {{WIDTH{1'b0}}, Ain};
        b_q     <= Bin;
        acc_q   <= '0;
        cnt_q   <= SHW'(WIDTH - 1);
      end else if (state_q == MUL) begin
        acc_q   <= acc_next;
        mcand_q <= mcand_q << 1;
        b_q     <= b_q >> 1;
        cnt_q   <= cnt_q - SHW'(1);
      end
      if (load_alu | load_mul) begin
        out       <= res_d;
        Z         <= (res_d == '0);
        N         <= res_d[WIDTH-1];
        V         <= v_d;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed literal cases, then randomized traffic checked every cycle
// against a queue-based model of results, due cycles and handshake expectations.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_ready, out_valid, Z, N, V, busy;
  logic [15:0] Ain, Bin, out;
  logic [2:0]  ALUop;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(16), .SHW(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Ain(Ain), .Bin(Bin), .ALUop(ALUop), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .Z(Z), .N(N), .V(V), .busy(busy)
  );

  typedef struct {
    logic [15:0] r;
    logic        z;
    logic        n;
    logic        v;
    int          due;
    logic        mul;
  } exp_t;

  exp_t q[$];
  exp_t e;
  logic post_rst = 1'b0;
  logic ev, mp, er;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference results from plain integer arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t   m;
    int     sa, sb, s;
    longint p;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s = 0;
    p = 0;
    m.r = 16'h0;
    m.v = 1'b0;
    m.due = 0;
    m.mul = (op == 3'd7);
    case (op)
      3'd0: begin s = sa + sb; m.r = s[15:0]; m.v = (s > 32767) || (s < -32768); end
      3'd1: begin s = sa - sb; m.r = s[15:0]; m.v = (s > 32767) || (s < -32768); end
      3'd2: m.r = a & b;
      3'd3: m.r = ~b;
      3'd4: m.r = a | b;
      3'd5: m.r = a ^ b;
      3'd6: begin p = longint'(a) << b[3:0]; m.r = p[15:0]; end
      default: begin p = longint'(a) * longint'(b); m.r = p[15:0]; m.v = (p > 65535); end
    endcase
    m.z = (m.r == 16'h0);
    m.n = m.r[15];
    return m;
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      q.delete();
      post_rst = 1'b1;
      chk("in_ready_during_reset", 32'(in_ready), 32'd0);
    end else begin
      ev = (q.size() > 0) && (cyc >= q[0].due);
      mp = (q.size() > 0) && q[0].mul && (cyc < q[0].due);
      er = !mp && (!ev || out_ready);
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("in_ready", 32'(in_ready), 32'(er));
      chk("busy", 32'(busy), 32'(mp));
      if (ev) begin
        chk("out", 32'(out), 32'(q[0].r));
        chk("Z", 32'(Z), 32'(q[0].z));
        chk("N", 32'(N), 32'(q[0].n));
        chk("V", 32'(V), 32'(q[0].v));
      end
      if (post_rst) begin
        chk("out_after_reset", 32'(out), 32'd0);
        chk("flags_after_reset", 32'({Z, N, V}), 32'd0);
        post_rst = 1'b0;
      end
      if (ev && out_ready) void'(q.pop_front());
      if (in_valid && er) begin
        e = model(ALUop, Ain, Bin);
        e.due = cyc + (e.mul ? 17 : 1);
        q.push_back(e);
      end
    end
  end

  // Presents an op and returns just after the accepting edge; keep=0 drops in_valid there.
  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input bit keep);
    int n = 0;
    in_valid = 1'b1;
    ALUop = op;
    Ain = a;
    Bin = b;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("accept_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input int lat);
    int n = 1;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk(name, 32'(n), 32'(lat));
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    Ain = 16'h0;
    Bin = 16'h0;
    ALUop = 3'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // reset in the middle of a multiply
    send(3'd7, 16'd7, 16'd9, 1'b0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midmul_rst_valid", 32'(out_valid), 32'd0);
    chk("midmul_rst_out", 32'(out), 32'd0);
    chk("midmul_rst_busy", 32'(busy), 32'd0);
    chk("midmul_rst_ready", 32'(in_ready), 32'd1);
    chk("midmul_rst_flags", 32'({Z, N, V}), 32'd0);
    @(posedge clk);
    #1;

    send(3'd0, 16'h7FFF, 16'h0001, 1'b0);
    @(negedge clk);
    chk("add_ovf_out", 32'(out), 32'h8000);
    chk("add_ovf_znv", 32'({Z, N, V}), 32'b011);

    send(3'd1, 16'h1234, 16'h1234, 1'b1);
    ALUop = 3'd5;
    Ain = 16'hF0F0;
    Bin = 16'h0FF0;
    @(negedge clk);
    chk("sub_zero_out", 32'(out), 32'h0000);
    chk("sub_zero_Z", 32'(Z), 32'd1);
    chk("b2b_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("xor_out", 32'(out), 32'hFF00);
    chk("xor_zn", 32'({Z, N}), 32'b01);

    @(posedge clk);
    #1;
    send(3'd7, 16'h0100, 16'h0100, 1'b0);
    wait_out("mul_latency", 17);
    chk("mul_out", 32'(out), 32'h0000);
    chk("mul_zv", 32'({Z, V}), 32'b11);

    @(posedge clk);
    #1;
    send(3'd7, 16'd7, 16'd9, 1'b0);
    wait_out("mul2_latency", 17);
    chk("mul2_out", 32'(out), 32'd63);
    chk("mul2_v", 32'(V), 32'd0);

    @(posedge clk);
    #1 out_ready = 1'b0;
    send(3'd0, 16'd3, 16'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out", 32'(out), 32'd7);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(3'd2, 16'hFFFF, 16'h0F0F, 1'b0);
    @(negedge clk);
    chk("drain_accept_out", 32'(out), 32'h0F0F);
    chk("drain_accept_valid", 32'(out_valid), 32'd1);

    @(posedge clk);
    #1;
    send(3'd6, 16'h0001, 16'h000F, 1'b0);
    @(negedge clk);
    chk("shl_out", 32'(out), 32'h8000);
    chk("shl_nv", 32'({N, V}), 32'b10);
    @(posedge clk);
    #1;
    send(3'd3, 16'h1234, 16'h00FF, 1'b0);
    @(negedge clk);
    chk("notb_out", 32'(out), 32'hFF00);

    repeat (3000) begin
      @(posedge clk);
      #1;
      reset = ($urandom_range(0, 499) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      ALUop = 3'($urandom_range(0, 7));
      Ain = rnd16();
      Bin = rnd16();
      out_ready = ($urandom_range(0, 9) < 7);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
